// File: rtl/text_ram_scheduler.sv
`default_nettype none
// ============================================================================
// Module : text_ram_scheduler
// Brief  : Shares a single-port text RAM between display cell fetches,
//          a screen-clear engine and a host write port (fetch has priority).
// Rev    : 1.0 - initial release
// ============================================================================

module text_ram_scheduler #(
    parameter int          COLS      = 60,
    parameter int          ROWS      = 34,
    parameter int          ADDR_W    = 11,
    parameter logic [7:0]  BLANK_CHR = 8'h20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [8:0]        i_x,
    input  logic [8:0]        i_y,
    input  logic              i_hde,
    input  logic              i_vde,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_clear,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [7:0]        o_ram_wdata,
    input  logic [7:0]        i_ram_rdata,
    output logic [7:0]        o_chr
);

    localparam int unsigned       c_NUM_CELLS = COLS * ROWS;
    localparam logic [6:0]        c_COLS      = 7'(COLS);
    localparam logic [5:0]        c_ROWS      = 6'(ROWS);
    localparam logic [ADDR_W-1:0] c_COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W:0]   c_CELLS_X   = (ADDR_W + 1)'(c_NUM_CELLS);
    localparam logic [ADDR_W-1:0] c_LAST_CELL = ADDR_W'(c_NUM_CELLS - 1);
    localparam logic [ADDR_W-1:0] c_ONE       = ADDR_W'(1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [7:0]        r_ram_wdata;
    logic [7:0]        r_prefetch;
    logic [7:0]        r_chr;
    logic              r_slot_d1;
    logic              r_slot_d2;

    logic [6:0]        w_tcol;
    logic [5:0]        w_row;
    logic              w_x4;
    logic              w_row_ok;
    logic              w_slot;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic              w_wr_fire;
    logic              w_wr_in_range;
    logic              w_unused_y;

    // Column fetched at x[2:0]==4 is the one displayed in the next cell; in hblank it is col 0.
    assign w_tcol        = i_hde ? ({1'b0, i_x[8:3]} + 7'd1) : 7'd0;
    assign w_row         = i_y[8:3];
    assign w_x4          = i_vde & (i_x[2:0] == 3'd4);
    assign w_row_ok      = (w_row < c_ROWS);
    assign w_slot        = w_x4 & (w_tcol < c_COLS) & w_row_ok;
    assign w_fetch_addr  = (ADDR_W'(w_row) * c_COLS_A) + ADDR_W'(w_tcol);
    assign w_wr_in_range = ({1'b0, i_wr_addr} < c_CELLS_X);
    assign w_unused_y    = &{1'b0, i_y[2:0]};

    assign o_wr_ready  = ~w_slot & (r_state == c_ST_IDLE) & ~i_clear;
    assign w_wr_fire   = i_wr_valid & o_wr_ready;

    assign o_busy      = r_busy;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_we    = r_ram_we;
    assign o_ram_wdata = r_ram_wdata;
    assign o_chr       = r_chr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= 8'h00;
            r_prefetch  <= BLANK_CHR;
            r_chr       <= BLANK_CHR;
            r_slot_d1   <= 1'b0;
            r_slot_d2   <= 1'b0;
        end else begin
            r_ram_we  <= 1'b0;
            r_slot_d1 <= w_slot;
            r_slot_d2 <= r_slot_d1;

            if (w_slot) begin
                r_ram_addr <= w_fetch_addr;
            end else if (r_state == c_ST_CLEAR) begin
                r_ram_addr  <= r_cnt;
                r_ram_we    <= 1'b1;
                r_ram_wdata <= BLANK_CHR;
                if (r_cnt == c_LAST_CELL) begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end else if (w_wr_fire) begin
                // Out-of-range writes still complete the handshake but never reach the RAM.
                r_ram_addr  <= i_wr_addr;
                r_ram_we    <= w_wr_in_range;
                r_ram_wdata <= i_wr_data;
            end

            if ((r_state == c_ST_IDLE) && i_clear) begin
                r_state <= c_ST_CLEAR;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end

            // Read data for a slot issued at x==4 arrives two cycles later, at x==6.
            if (w_x4 && !w_row_ok) begin
                r_prefetch <= BLANK_CHR;
            end else if (r_slot_d2) begin
                r_prefetch <= i_ram_rdata;
            end

            if (i_vde && (i_x[2:0] == 3'd7)) begin
                r_chr <= r_prefetch;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_text_ram_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_text_ram_scheduler
// Brief  : Directed self-checking bench for text_ram_scheduler with a RAM model.
// Rev    : 1.0 - initial release
// ============================================================================

module tb_text_ram_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  x_in;
    logic [8:0]  y_in;
    logic        hde;
    logic        vde;
    logic        wr_valid;
    logic        wr_ready;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        clear;
    logic        busy;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  chr;
    logic        ram_init;

    logic [7:0]  mem [0:2047];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    text_ram_scheduler dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_x         (x_in),
        .i_y         (y_in),
        .i_hde       (hde),
        .i_vde       (vde),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_clear     (clear),
        .o_busy      (busy),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_chr       (chr)
    );

    // Single-port RAM, 1-cycle registered read; preloaded with blanks while ram_init is high.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'h20;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic slot_of(input int x, input int y, input logic h, input logic v);
        int tcol;
        tcol = h ? (x / 8) + 1 : 0;
        return v && ((x % 8) == 4) && (tcol < 60) && ((y / 8) < 34);
    endfunction

    task automatic drive_px(input int x, input int y, input logic h, input logic v);
        @(negedge clk);
        x_in = 9'(x);
        y_in = 9'(y);
        hde  = h;
        vde  = v;
    endtask

    task automatic host_write(input int addr, input logic [7:0] data, input logic exp_we);
        @(negedge clk);
        vde      = 1'b0;
        hde      = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 11'(addr);
        wr_data  = data;
        #1;
        check("wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check("wr_we", 32'(ram_we), 32'(exp_we));
        if (exp_we) begin
            check("wr_addr", 32'(ram_addr), 32'(addr));
            check("wr_wdata", 32'(ram_wdata), 32'(data));
        end
    endtask

    task automatic hblank(input int y);
        for (int x = 488; x < 512; x++) drive_px(x, y, 1'b0, 1'b1);
    endtask

    initial begin
        int   n_we;
        int   n_bad;
        int   xc;
        int   yc;
        logic prev_slot;

        rst = 1'b1; ram_init = 1'b1;
        x_in = '0; y_in = '0; hde = 1'b0; vde = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear = 1'b0;

        // T1 reset
        repeat (2) @(negedge clk);
        rst = 1'b0; ram_init = 1'b0;
        #1;
        check("rst_chr", 32'(chr), 32'h20);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd1);

        // T2 write then display row 1
        host_write(61, 8'h41, 1'b1);
        hblank(8);
        for (int x = 0; x < 480; x++) begin
            drive_px(x, 8, 1'b1, 1'b1);
            #1;
            check("t2_chr", 32'(chr), (x >= 8 && x < 16) ? 32'h41 : 32'h20);
        end
        drive_px(0, 0, 1'b0, 1'b0);

        // T3 write request colliding with a fetch slot
        hblank(8);
        for (int x = 0; x < 16; x++) begin
            drive_px(x, 8, 1'b1, 1'b1);
            if (x == 4) begin
                wr_valid = 1'b1; wr_addr = 11'd100; wr_data = 8'h42;
            end
            if (x == 6) wr_valid = 1'b0;
            #1;
            if (x == 4) check("t3_ready_slot", 32'(wr_ready), 32'd0);
            if (x == 5) begin
                check("t3_ready_free", 32'(wr_ready), 32'd1);
                check("t3_fetch_addr", 32'(ram_addr), 32'd61);
                check("t3_fetch_we", 32'(ram_we), 32'd0);
            end
            if (x == 6) begin
                check("t3_wr_we", 32'(ram_we), 32'd1);
                check("t3_wr_addr", 32'(ram_addr), 32'd100);
                check("t3_wr_data", 32'(ram_wdata), 32'h42);
            end
            if (x >= 8) check("t3_chr", 32'(chr), 32'h41);
        end
        drive_px(0, 0, 1'b0, 1'b0);
        #1;
        check("t3_mem", 32'(mem[100]), 32'h42);

        // T4 fill with 0x55, then clear during active video
        for (int a = 0; a < 2040; a++) host_write(a, 8'h55, 1'b1);
        n_we = 0; xc = 0; yc = 0; prev_slot = 1'b0;
        for (int cyc = 0; cyc < 6000 && n_we < 2040; cyc++) begin
            drive_px(xc, yc, xc < 480, yc < 272);
            clear    = (cyc == 98);
            wr_valid = (cyc == 98);
            wr_addr  = 11'd5;
            wr_data  = 8'h66;
            #1;
            if (cyc == 98) check("t4_clr_ready", 32'(wr_ready), 32'd0);
            if (cyc == 99) begin
                check("t4_busy_set", 32'(busy), 32'd1);
                check("t4_no_host_we", 32'(ram_we), 32'd0);
            end
            if (ram_we) begin
                n_we++;
                check("t4_clr_addr", 32'(ram_addr), 32'(n_we - 1));
                check("t4_clr_data", 32'(ram_wdata), 32'h20);
                check("t4_clr_busy", 32'(busy), (n_we != 2040) ? 32'd1 : 32'd0);
                check("t4_we_after_slot", 32'(prev_slot), 32'd0);
            end
            if (busy) check("t4_ready_busy", 32'(wr_ready), 32'd0);
            prev_slot = slot_of(xc, yc, xc < 480, yc < 272);
            xc++;
            if (xc == 512) begin
                xc = 0;
                yc = (yc == 287) ? 0 : yc + 1;
            end
        end
        clear = 1'b0; wr_valid = 1'b0;
        check("t4_clr_count", 32'(n_we), 32'd2040);
        drive_px(0, 0, 1'b0, 1'b0);
        #1;
        check("t4_busy_end", 32'(busy), 32'd0);
        check("t4_ready_end", 32'(wr_ready), 32'd1);
        n_bad = 0;
        for (int a = 0; a < 2040; a++) if (mem[a] !== 8'h20) n_bad++;
        check("t4_cells_blank", 32'(n_bad), 32'd0);

        // T5 out-of-range write
        host_write(2040, 8'h7F, 1'b0);
        drive_px(0, 0, 1'b0, 1'b0);
        #1;
        check("t5_cell_2039", 32'(mem[2039]), 32'h20);

        // T6 reset in the middle of a clear
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_we = 0;
        for (int cyc = 0; cyc < 500 && n_we < 100; cyc++) begin
            @(negedge clk);
            #1;
            if (ram_we) n_we++;
        end
        check("t6_count", 32'(n_we), 32'd100);
        check("t6_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("t6_busy_rst", 32'(busy), 32'd0);
        check("t6_we_rst", 32'(ram_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("t6_ready", 32'(wr_ready), 32'd1);
        check("t6_busy_after", 32'(busy), 32'd0);
        check("t6_we_after", 32'(ram_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
